fetch_unit: RTL and testbench

//  Instruction-fetch stage that directly feeds the IF/ID pipeline register with pc_out/instruction.

---
 rtl/rv_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 72 +++++++
 rtl/fetch_unit.sv | 110 +++++++++++
 tb/tb_fetch_unit.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RV32 fetch-path constants and the fetch-buffer entry type.
package rv_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, instr} pairs; flush empties it in one cycle.
module fetch_fifo
    import rv_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           flush_i,
    input  logic                           push_i,
    input  fetch_entry_t                   push_data_i,
    input  logic                           pop_i,
    output fetch_entry_t                   head_o,
    output logic [$clog2(DEPTH + 1)-1:0]   count_o
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t    mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            do_push, do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign do_pop  = pop_i && (count_q != '0);
    // A push into a full buffer is only legal when the head leaves in the same cycle.
    assign do_push = push_i && ((count_q != CntW'(DEPTH)) || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues in-order memory requests, buffers returned
// words and presents them to IF/ID, dropping wrong-path responses after a redirect.
module fetch_unit
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FBUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] pc_out,
    output logic [31:0] instruction,
    output logic        if_valid
);

    localparam int unsigned CntW = $clog2(FBUF_DEPTH + 1);
    localparam logic [CntW:0] Capacity = (CntW + 1)'(FBUF_DEPTH);

    logic [XLEN-1:0] pc_fetch_q, pc_fetch_d;
    logic [XLEN-1:0] pc_rsp_q, pc_rsp_d;
    logic [XLEN-1:0] last_pc_q, last_pc_d;
    logic [CntW-1:0] outstanding_q, outstanding_d;
    logic [CntW-1:0] drop_cnt_q, drop_cnt_d;
    logic [CntW-1:0] fifo_count;
    logic [XLEN-1:0] redirect_pc;
    logic            issue, push, pop, fifo_empty;
    fetch_entry_t    push_entry, head;

    assign redirect_pc = branch_target & ~32'h3;
    assign fifo_empty  = (fifo_count == '0);

    // Requests in flight plus buffered words never exceed the buffer, so pushes cannot overflow.
    assign imem_req_valid = reset && !branch_taken &&
                            (({1'b0, outstanding_q} + {1'b0, fifo_count}) < Capacity);
    assign imem_req_addr  = pc_fetch_q;
    assign issue          = imem_req_valid && imem_req_ready;

    assign push       = imem_rsp_valid && !branch_taken && (drop_cnt_q == '0);
    assign pop        = !stall && !branch_taken && !fifo_empty;
    assign push_entry = '{pc: pc_rsp_q, instr: imem_rsp_data};

    fetch_fifo #(
        .DEPTH (FBUF_DEPTH)
    ) u_fetch_fifo (
        .clk_i       (clk),
        .rst_ni      (reset),
        .flush_i     (branch_taken),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (fifo_count)
    );

    assign if_valid    = !branch_taken && !fifo_empty;
    assign instruction = if_valid ? head.instr : NOP_INSTR;
    assign pc_out      = if_valid ? head.pc : last_pc_q;

    always_comb begin
        pc_fetch_d    = pc_fetch_q;
        pc_rsp_d      = pc_rsp_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;
        last_pc_d     = last_pc_q;

        if (if_valid) last_pc_d = head.pc;

        case ({issue, imem_rsp_valid})
            2'b10:   outstanding_d = outstanding_q + CntW'(1);
            2'b01:   outstanding_d = outstanding_q - CntW'(1);
            default: outstanding_d = outstanding_q;
        endcase

        if (branch_taken) begin
            // Everything still in flight is wrong-path; a response arriving now is discarded.
            pc_fetch_d = redirect_pc;
            pc_rsp_d   = redirect_pc;
            drop_cnt_d = imem_rsp_valid ? outstanding_q - CntW'(1) : outstanding_q;
        end else begin
            if (issue) pc_fetch_d = pc_fetch_q + PC_STEP;
            if (imem_rsp_valid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CntW'(1);
            if (push) pc_rsp_d = pc_rsp_q + PC_STEP;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_fetch_q    <= RESET_PC;
            pc_rsp_q      <= RESET_PC;
            last_pc_q     <= '0;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            pc_fetch_q    <= pc_fetch_d;
            pc_rsp_q      <= pc_rsp_d;
            last_pc_q     <= last_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then randomized traffic against an in-order
// memory model and a "sequential PCs from the last redirect" reference.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned DEPTH    = 2;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk;
    logic        reset, stall, branch_taken;
    logic [31:0] branch_target;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] pc_out, instruction;
    logic        if_valid;

    fetch_unit #(
        .RESET_PC   (RESET_PC),
        .FBUF_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .pc_out         (pc_out),
        .instruction    (instruction),
        .if_valid       (if_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t        memq[$];
    int          cyc = 0;
    int          lat_extra = 0;
    int          pops = 0;
    int          n_pass = 0;
    int          n_fail = 0;
    int          n_total = 0;
    logic [31:0] exp_pc, exp_fetch, last_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        n_total++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    // One clock cycle: drive the memory response, check outputs against the model for the
    // upcoming edge, advance the model, then cross the edge.
    task automatic tick();
        if (reset && memq.size() > 0 && memq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(memq[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom();
        end
        #2;
        if (!reset) begin
            chk1("rst_req_valid", imem_req_valid, 1'b0);
            memq.delete();
            exp_pc    = RESET_PC;
            exp_fetch = RESET_PC;
            last_pc   = 32'h0;
        end else begin
            if (imem_rsp_valid) void'(memq.pop_front());
            if (branch_taken) begin
                chk1("redir_if_valid", if_valid, 1'b0);
                chk("redir_instr", instruction, NOP);
                chk1("redir_req_valid", imem_req_valid, 1'b0);
                exp_pc    = branch_target & ~32'h3;
                exp_fetch = branch_target & ~32'h3;
            end else begin
                if (if_valid) begin
                    chk("pc_out", pc_out, exp_pc);
                    chk("instruction", instruction, mem_word(exp_pc));
                    last_pc = exp_pc;
                    if (!stall) begin
                        exp_pc = exp_pc + 32'd4;
                        pops++;
                    end
                end else begin
                    chk("bubble_instr", instruction, NOP);
                    chk("bubble_pc_hold", pc_out, last_pc);
                end
                if (imem_req_valid) begin
                    chk("req_addr", imem_req_addr, exp_fetch);
                    if (imem_req_ready) begin
                        memq.push_back('{addr: exp_fetch, due: cyc + 1 + lat_extra});
                        exp_fetch = exp_fetch + 32'd4;
                    end
                end
                chk1("capacity", (memq.size() <= DEPTH), 1'b1);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        logic [31:0] tgt;
        reset          = 1'b0;
        stall          = 1'b0;
        branch_taken   = 1'b0;
        branch_target  = 32'h0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        exp_pc         = RESET_PC;
        exp_fetch      = RESET_PC;
        last_pc        = 32'h0;
        repeat (3) tick();
        #1;
        chk1("reset_if_valid", if_valid, 1'b0);
        chk("reset_instr", instruction, NOP);
        chk("reset_pc_out", pc_out, 32'h0);

        // 1: release with 1-cycle memory; first word presented two edges later.
        reset          = 1'b1;
        imem_req_ready = 1'b1;
        #1;
        chk1("t1_req_valid", imem_req_valid, 1'b1);
        chk("t1_addr0", imem_req_addr, RESET_PC);
        tick();
        #1;
        chk1("t1_ifv_c1", if_valid, 1'b0);
        tick();
        #1;
        chk1("t1_ifv_c2", if_valid, 1'b1);
        chk("t1_pc_c2", pc_out, 32'h0);
        repeat (6) tick();

        // 2: stall with memory still ready; buffer fills and outputs hold.
        stall = 1'b1;
        repeat (5) tick();
        #1;
        chk1("t2_hold_valid", if_valid, 1'b1);
        stall = 1'b0;
        repeat (6) tick();

        // 3: redirect to unaligned target with two requests in flight.
        lat_extra = 3;
        for (int i = 0; i < 20 && memq.size() != 2; i++) tick();
        chk1("t3_two_inflight", (memq.size() == 2), 1'b1);
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0102;
        tick();
        branch_taken = 1'b0;
        #1;
        chk("t3_next_addr", imem_req_addr, 32'h0000_0100);
        for (int i = 0; i < 40 && !if_valid; i++) begin
            tick();
            #1;
        end
        chk1("t3_valid_seen", if_valid, 1'b1);
        chk("t3_first_pc", pc_out, 32'h0000_0100);
        repeat (4) tick();

        // 4: memory not ready for 10 cycles; address holds and buffer drains.
        lat_extra      = 0;
        imem_req_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            #1;
            chk("t4_addr_hold", imem_req_addr, exp_fetch);
        end
        chk1("t4_drained_valid", if_valid, 1'b0);
        chk("t4_drained_instr", instruction, NOP);

        // 5: redirect coinciding with a response while stalled.
        imem_req_ready = 1'b1;
        stall          = 1'b1;
        tick();
        branch_taken  = 1'b1;
        branch_target = 32'h0000_2000;
        tick();
        branch_taken = 1'b0;
        #1;
        chk1("t5_if_valid", if_valid, 1'b0);
        chk("t5_instr", instruction, NOP);
        chk("t5_restart_addr", imem_req_addr, 32'h0000_2000);
        for (int i = 0; i < 20 && !if_valid; i++) begin
            tick();
            #1;
        end
        chk("t5_first_pc", pc_out, 32'h0000_2000);
        stall = 1'b0;
        repeat (6) tick();

        // 6: reset mid-stream with two outstanding requests.
        lat_extra = 3;
        for (int i = 0; i < 20 && memq.size() != 2; i++) tick();
        chk1("t6_two_inflight", (memq.size() == 2), 1'b1);
        reset = 1'b0;
        tick();
        #1;
        chk1("t6_req_valid", imem_req_valid, 1'b0);
        chk1("t6_if_valid", if_valid, 1'b0);
        tick();
        reset = 1'b1;
        #1;
        chk1("t6_resume_valid", imem_req_valid, 1'b1);
        chk("t6_resume_addr", imem_req_addr, RESET_PC);
        repeat (8) tick();

        // Randomized traffic.
        pops = 0;
        for (int i = 0; i < 3000; i++) begin
            reset          = ($urandom_range(0, 199) != 0);
            stall          = ($urandom_range(0, 9) < 3);
            imem_req_ready = ($urandom_range(0, 9) < 7);
            lat_extra      = $urandom_range(0, 3);
            tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom() & 32'hF))
                                              : $urandom();
            branch_taken   = reset && ($urandom_range(0, 19) == 0);
            branch_target  = tgt;
            tick();
        end
        branch_taken = 1'b0;
        reset        = 1'b1;
        chk1("rand_progress", (pops > 200), 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
